// File: rtl/rice_core_div_sequencer.sv
// ============================================================================
//  Module   : rice_core_div_sequencer
//  Purpose  : Iterative radix-2 restoring divider (RV32M DIV/DIVU/REM/REMU).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rice_core_div_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_flush,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [3:0]      i_operation,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_result
);

   localparam int C_CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [C_CNT_W-1:0]  r_count;
   logic [XLEN-1:0]     r_rem;
   logic [XLEN-1:0]     r_quo;
   logic [XLEN-1:0]     r_dvs;
   logic                r_is_rem;
   logic                r_neg_q;
   logic                r_neg_r;
   logic [XLEN-1:0]     r_result;

   // Operation is one-hot {div,divu,rem,remu}; priority encoding, zero -> divu
   logic w_op_signed;
   logic w_op_rem;
   assign w_op_signed = i_operation[3] | (~i_operation[2] & i_operation[1]);
   assign w_op_rem    = ~i_operation[3] & ~i_operation[2] &
                        (i_operation[1] | i_operation[0]);

   logic            w_neg1;
   logic            w_neg2;
   logic [XLEN-1:0] w_abs1;
   logic [XLEN-1:0] w_abs2;
   logic            w_div_zero;
   logic            w_ovf;
   logic            w_accept;

   assign w_neg1     = w_op_signed & i_rs1[XLEN-1];
   assign w_neg2     = w_op_signed & i_rs2[XLEN-1];
   assign w_abs1     = w_neg1 ? -i_rs1 : i_rs1;
   assign w_abs2     = w_neg2 ? -i_rs2 : i_rs2;
   assign w_div_zero = (i_rs2 == '0);
   assign w_ovf      = w_op_signed && (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                       (i_rs2 == '1);
   assign w_accept   = (r_state == S_IDLE) && i_valid && !i_flush;

   // Shifted partial remainder needs one extra bit: with a large unsigned
   // divisor, 2*rem+1 can exceed XLEN bits before the trial subtract.
   logic [XLEN:0]   w_shift;
   logic            w_ge;
   logic [XLEN-1:0] w_diff;
   logic [XLEN-1:0] w_rem_next;
   logic [XLEN-1:0] w_quo_next;
   logic [XLEN-1:0] w_q_fix;
   logic [XLEN-1:0] w_r_fix;
   logic            w_last;

   assign w_shift    = {r_rem, r_quo[XLEN-1]};
   assign w_ge       = (w_shift >= {1'b0, r_dvs});
   assign w_diff     = w_shift[XLEN-1:0] - r_dvs;
   assign w_rem_next = w_ge ? w_diff : w_shift[XLEN-1:0];
   assign w_quo_next = {r_quo[XLEN-2:0], w_ge};
   assign w_q_fix    = r_neg_q ? -w_quo_next : w_quo_next;
   assign w_r_fix    = r_neg_r ? -w_rem_next : w_rem_next;
   assign w_last     = (r_count == C_CNT_W'(XLEN-1));

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_next = (w_div_zero || w_ovf) ? S_DONE : S_CALC;
         S_CALC: if (w_last)   w_state_next = S_DONE;
         S_DONE: if (i_ready)  w_state_next = S_IDLE;
         default:              w_state_next = S_IDLE;
      endcase
      if (i_flush) w_state_next = S_IDLE;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_count  <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvs    <= '0;
         r_is_rem <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_result <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_count  <= '0;
            r_rem    <= '0;
            r_quo    <= w_abs1;
            r_dvs    <= w_abs2;
            r_is_rem <= w_op_rem;
            r_neg_q  <= w_neg1 ^ w_neg2;
            r_neg_r  <= w_neg1;
            if (w_div_zero)
               r_result <= w_op_rem ? i_rs1 : '1;
            else if (w_ovf)
               r_result <= w_op_rem ? '0 : i_rs1;
         end else if (r_state == S_CALC && !i_flush) begin
            r_rem   <= w_rem_next;
            r_quo   <= w_quo_next;
            r_count <= r_count + C_CNT_W'(1);
            if (w_last)
               r_result <= r_is_rem ? w_r_fix : w_q_fix;
         end
      end
   end

   assign o_ready  = (r_state == S_IDLE);
   assign o_valid  = (r_state == S_DONE);
   assign o_result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_rice_core_div_sequencer.sv
// ============================================================================
//  Module   : tb_rice_core_div_sequencer
//  Purpose  : Directed vector bench for rice_core_div_sequencer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rice_core_div_sequencer;

   localparam logic [3:0] OP_DIV  = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b0100;
   localparam logic [3:0] OP_REM  = 4'b0010;
   localparam logic [3:0] OP_REMU = 4'b0001;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready_o;
   logic [3:0]  operation;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rice_core_div_sequencer #(.XLEN(32)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_flush     (flush),
      .i_valid     (in_valid),
      .o_ready     (in_ready_o),
      .i_operation (operation),
      .i_rs1       (rs1),
      .i_rs2       (rs2),
      .o_valid     (out_valid),
      .i_ready     (out_ready),
      .o_result    (result)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Present a request in the current cycle and step past the accept edge.
   task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      operation = op;
      rs1       = a;
      rs2       = b;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      operation = 4'b1111;
      rs1       = 32'hDEAD_BEEF;
      rs2       = 32'h0000_0003;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
      start_op(op, a, b);
      wait_valid(lat);
      res = result;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] res;
   int          lat;
   int          seen;

   initial begin
      vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         33};
      vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          33};
      vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
      vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
      vecs[4]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};
      vecs[5]  = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
      vecs[6]  = '{OP_REMU, 32'd5,          32'd0,          32'd5,          1};
      vecs[7]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
      vecs[8]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
      vecs[9]  = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
      vecs[10] = '{4'b0000, 32'd100,        32'd7,          32'd14,         33};
      vecs[11] = '{4'b1111, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
      vecs[12] = '{OP_DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          33};
      vecs[13] = '{OP_REMU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          33};
      vecs[14] = '{OP_DIV,  32'd0,          32'd5,          32'd0,          33};
      vecs[15] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
      vecs[16] = '{OP_DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          33};
      vecs[17] = '{OP_REM,  32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'hFFFF_FFFE,  33};
      vecs[18] = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
      vecs[19] = '{OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};

      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      operation = 4'b0;
      rs1       = '0;
      rs2       = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_ready",  {31'b0, in_ready_o}, 32'd1);
      check("reset_valid",  {31'b0, out_valid},  32'd0);
      check("reset_result", result,              32'd0);

      for (int i = 0; i < 20; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
         check($sformatf("vec%0d_result", i), res, vecs[i].exp);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("vec%0d_ready_after", i), {31'b0, in_ready_o}, 32'd1);
      end

      // Backpressure: result must hold for 10 cycles with i_ready low
      out_ready = 1'b0;
      start_op(OP_DIVU, 32'd100, 32'd7);
      wait_valid(lat);
      check("bp_latency", 32'(lat), 32'd33);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_valid",  {31'b0, out_valid},  32'd1);
         check("bp_result", result,              32'd14);
         check("bp_ready",  {31'b0, in_ready_o}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_ready", {31'b0, in_ready_o}, 32'd1);
      check("bp_release_valid", {31'b0, out_valid},  32'd0);

      // Flush while the counter is at 10
      start_op(OP_DIVU, 32'd1000, 32'd7);
      repeat (10) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_ready", {31'b0, in_ready_o}, 32'd1);
      check("flush_valid", {31'b0, out_valid},  32'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      check("flush_no_result", 32'(seen), 32'd0);
      do_op(OP_DIVU, 32'd9, 32'd3, res, lat);
      check("post_flush_result",  res,      32'd3);
      check("post_flush_latency", 32'(lat), 32'd33);

      // Request coinciding with flush in IDLE is dropped
      flush = 1'b1;
      operation = OP_DIVU;
      rs1 = 32'd50;
      rs2 = 32'd5;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      check("vflush_ready", {31'b0, in_ready_o}, 32'd1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid || !in_ready_o) seen++;
      end
      check("vflush_no_accept", 32'(seen), 32'd0);

      // Reset in CALC clears o_result as well
      start_op(OP_DIVU, 32'd100, 32'd7);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_calc_valid",  {31'b0, out_valid},  32'd0);
      check("rst_calc_result", result,              32'd0);
      check("rst_calc_ready",  {31'b0, in_ready_o}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
